// File: rtl/nios_mult_cell_pipe.sv
// Pipelined Nios II integer multiplier cell: four half-width partial products,
// assembled with high-word sign correction, 1..3 enabled-cycle latency.
module nios_mult_cell_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_op,
    input  logic              E_valid,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_result,
    output logic              M_valid,
    output logic              M_busy
);

    localparam int HALF_W = DATA_W / 2;
    localparam int MSB    = DATA_W - 1;
    localparam int PW     = 2 * DATA_W;

    if ((DATA_W % 2) != 0 || DATA_W < 16 || DATA_W > 64) begin : g_bad_w
        $error("nios_mult_cell_pipe: DATA_W must be even, 16..64");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_s
        $error("nios_mult_cell_pipe: STAGES must be 1..3");
    end

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [1:0]        w_op;
    logic              w_v;
    logic              w_in_busy;

    if (STAGES == 3) begin : g_in
        logic [DATA_W-1:0] r_a;
        logic [DATA_W-1:0] r_b;
        logic [1:0]        r_op;
        logic              r_v;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= '0;
                r_v  <= 1'b0;
            end else begin
                if (M_en) begin
                    r_a  <= E_src1;
                    r_b  <= E_src2;
                    r_op <= E_op;
                end
                if (M_flush) r_v <= 1'b0;
                else if (M_en) r_v <= E_valid;
            end
        end

        assign w_a       = r_a;
        assign w_b       = r_b;
        assign w_op      = r_op;
        assign w_v       = r_v;
        assign w_in_busy = r_v;
    end else begin : g_no_in
        assign w_a       = E_src1;
        assign w_b       = E_src2;
        assign w_op      = E_op;
        assign w_v       = E_valid;
        assign w_in_busy = 1'b0;
    end

    logic [HALF_W-1:0] w_al, w_ah, w_bl, w_bh;
    logic [DATA_W-1:0] w_pll, w_plh, w_phl, w_phh;
    logic [DATA_W-1:0] w_corr;

    assign w_al = w_a[HALF_W-1:0];
    assign w_ah = w_a[DATA_W-1:HALF_W];
    assign w_bl = w_b[HALF_W-1:0];
    assign w_bh = w_b[DATA_W-1:HALF_W];

    assign w_pll = DATA_W'(w_al) * DATA_W'(w_bl);
    assign w_plh = DATA_W'(w_al) * DATA_W'(w_bh);
    assign w_phl = DATA_W'(w_ah) * DATA_W'(w_bl);
    assign w_phh = DATA_W'(w_ah) * DATA_W'(w_bh);

    // Signed-operand correction to subtract from the unsigned high word
    assign w_corr = ((w_op[1] && w_a[MSB]) ? w_b : '0)
                  + ((w_op == 2'b11 && w_b[MSB]) ? w_a : '0);

    logic [DATA_W-1:0] x_pll, x_plh, x_phl, x_phh, x_corr;
    logic [1:0]        x_op;
    logic              x_v;
    logic              w_pp_busy;

    if (STAGES >= 2) begin : g_pp
        logic [DATA_W-1:0] r_pll, r_plh, r_phl, r_phh, r_corr;
        logic [1:0]        r_op;
        logic              r_v;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pll  <= '0;
                r_plh  <= '0;
                r_phl  <= '0;
                r_phh  <= '0;
                r_corr <= '0;
                r_op   <= '0;
                r_v    <= 1'b0;
            end else begin
                if (M_en) begin
                    r_pll  <= w_pll;
                    r_plh  <= w_plh;
                    r_phl  <= w_phl;
                    r_phh  <= w_phh;
                    r_corr <= w_corr;
                    r_op   <= w_op;
                end
                if (M_flush) r_v <= 1'b0;
                else if (M_en) r_v <= w_v;
            end
        end

        assign x_pll     = r_pll;
        assign x_plh     = r_plh;
        assign x_phl     = r_phl;
        assign x_phh     = r_phh;
        assign x_corr    = r_corr;
        assign x_op      = r_op;
        assign x_v       = r_v;
        assign w_pp_busy = r_v;
    end else begin : g_no_pp
        assign x_pll     = w_pll;
        assign x_plh     = w_plh;
        assign x_phl     = w_phl;
        assign x_phh     = w_phh;
        assign x_corr    = w_corr;
        assign x_op      = w_op;
        assign x_v       = w_v;
        assign w_pp_busy = 1'b0;
    end

    logic [DATA_W:0]   w_mid;
    logic [PW-1:0]     w_u;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_res;

    // Middle sum kept one bit wider so its carry reaches the high word
    assign w_mid = {1'b0, x_plh} + {1'b0, x_phl};
    assign w_u   = {x_phh, x_pll}
                 + {{(DATA_W-HALF_W-1){1'b0}}, w_mid, {HALF_W{1'b0}}};
    assign w_hi  = w_u[PW-1:DATA_W] - x_corr;
    assign w_res = (x_op == 2'b00) ? w_u[DATA_W-1:0] : w_hi;

    logic [DATA_W-1:0] r_res;
    logic              r_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res <= '0;
            r_vld <= 1'b0;
        end else begin
            if (M_en) r_res <= w_res;
            if (M_flush) r_vld <= 1'b0;
            else if (M_en) r_vld <= x_v;
        end
    end

    assign M_result = r_res;
    assign M_valid  = r_vld;
    assign M_busy   = w_in_busy | w_pp_busy;

endmodule

// File: tb/tb_nios_mult_cell_pipe.sv
// Bench for nios_mult_cell_pipe: directed vectors on a 32-bit/2-stage cell,
// plus random regression over every DATA_W/STAGES pairing.
module tb_nios_mult_cell_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] src1, src2;
    logic [1:0]  op;
    logic        ev, en, fl;
    logic [31:0] m_res;
    logic        m_vld, m_busy;
    int          total = 0;
    int          bad = 0;
    bit          sb_on = 1'b0;

    always #5 clk = ~clk;

    nios_mult_cell_pipe #(.DATA_W(32), .STAGES(2)) u_dut (
        .clk     (clk),
        .reset_n (rst_n),
        .E_src1  (src1[31:0]),
        .E_src2  (src2[31:0]),
        .E_op    (op),
        .E_valid (ev),
        .M_en    (en),
        .M_flush (fl),
        .M_result(m_res),
        .M_valid (m_vld),
        .M_busy  (m_busy)
    );

    for (genvar gi = 0; gi < 9; gi++) begin : g_cfg
        localparam int W = (gi / 3 == 0) ? 16 : ((gi / 3 == 1) ? 32 : 64);
        localparam int S = gi % 3 + 1;

        logic [W-1:0] r_res;
        logic         r_v, r_b;
        int           rem[$];
        logic [W-1:0] val[$];
        logic         mv;
        logic [W-1:0] md;

        nios_mult_cell_pipe #(.DATA_W(W), .STAGES(S)) u_r (
            .clk     (clk),
            .reset_n (rst_n),
            .E_src1  (src1[W-1:0]),
            .E_src2  (src2[W-1:0]),
            .E_op    (op),
            .E_valid (ev),
            .M_en    (en),
            .M_flush (fl),
            .M_result(r_res),
            .M_valid (r_v),
            .M_busy  (r_b)
        );

        // Reference: extend each operand per its signedness, multiply at 2W bits
        function automatic logic [W-1:0] ref_f(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [1:0] o);
            logic [2*W-1:0] ea, eb, p;
            ea = (o[1] && a[W-1]) ? {{W{1'b1}}, a} : {{W{1'b0}}, a};
            eb = (o == 2'b11 && b[W-1]) ? {{W{1'b1}}, b} : {{W{1'b0}}, b};
            p  = ea * eb;
            return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
        endfunction

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem.delete();
                val.delete();
                mv = 1'b0;
                md = '0;
            end else if (fl) begin
                rem.delete();
                val.delete();
                mv = 1'b0;
            end else if (en) begin
                foreach (rem[k]) rem[k]--;
                if (ev) begin
                    rem.push_back(S - 1);
                    val.push_back(ref_f(src1[W-1:0], src2[W-1:0], op));
                end
                mv = 1'b0;
                if (rem.size() > 0 && rem[0] == 0) begin
                    mv = 1'b1;
                    md = val[0];
                    void'(rem.pop_front());
                    void'(val.pop_front());
                end
            end
        end

        always @(negedge clk) begin
            if (sb_on) begin
                total++;
                if (r_v !== mv || (mv && r_res !== md)
                    || r_b !== (rem.size() != 0)) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL rnd W=%0d S=%0d: valid=%b res=%h busy=%b required valid=%b res=%h busy=%b",
                                 W, S, r_v, r_res, r_b, mv, md, rem.size() != 0);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o);
        src1 = {32'h0, a};
        src2 = {32'h0, b};
        op   = o;
        ev   = 1'b1;
    endtask

    initial begin
        vt[0] = '{32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F};
        vt[1] = '{32'h0001_0003, 32'h0002_0005, 2'b01, 32'h0000_0002};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000};
        vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF};
        vt[5] = '{32'h8000_0000, 32'h0000_0002, 2'b00, 32'h0000_0000};
        vt[6] = '{32'h8000_0000, 32'h0000_0002, 2'b11, 32'hFFFF_FFFF};
        vt[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000};
        vt[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000};
        vt[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001};

        rst_n = 1'b0;
        ev = 1'b0; en = 1'b0; fl = 1'b0; op = 2'b00;
        src1 = '0; src2 = '0;
        #12;
        chk("reset valid", {31'b0, m_vld}, 32'h0);
        chk("reset busy", {31'b0, m_busy}, 32'h0);
        chk("reset result", m_res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick;

        // Back-to-back high-word ops emerge in order
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01); tick;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11); tick;
        chk("b2b uu valid", {31'b0, m_vld}, 32'h1);
        chk("b2b uu", m_res, 32'hFFFF_FFFE);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10); tick;
        chk("b2b ss", m_res, 32'h0000_0000);
        ev = 1'b0; tick;
        chk("b2b su", m_res, 32'hFFFF_FFFF);
        tick;
        chk("b2b drain valid", {31'b0, m_vld}, 32'h0);

        // Stall holds the pipe, then the result emerges one edge later
        issue(32'd7, 32'd6, 2'b00); tick;
        ev = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall valid", {31'b0, m_vld}, 32'h0);
            chk("stall busy", {31'b0, m_busy}, 32'h1);
        end
        en = 1'b1; tick;
        chk("stall release valid", {31'b0, m_vld}, 32'h1);
        chk("stall release result", m_res, 32'h0000_002A);
        en = 1'b0;
        tick; tick;
        chk("stall out valid", {31'b0, m_vld}, 32'h1);
        chk("stall out result", m_res, 32'h0000_002A);
        en = 1'b1; tick;
        chk("stall out drain", {31'b0, m_vld}, 32'h0);

        // Flush kills in-flight ops and the op issued with it
        issue(32'd9, 32'd9, 2'b00); tick;
        issue(32'd5, 32'd5, 2'b00); tick;
        fl = 1'b1;
        issue(32'd3, 32'd4, 2'b01); tick;
        fl = 1'b0; ev = 1'b0;
        chk("flush valid", {31'b0, m_vld}, 32'h0);
        chk("flush busy", {31'b0, m_busy}, 32'h0);
        tick;
        chk("flush +1 valid", {31'b0, m_vld}, 32'h0);
        tick;
        chk("flush +2 valid", {31'b0, m_vld}, 32'h0);

        // Flush during stall
        issue(32'd7, 32'd6, 2'b00); tick;
        ev = 1'b0; en = 1'b0; fl = 1'b1; tick;
        chk("flush stall busy", {31'b0, m_busy}, 32'h0);
        chk("flush stall valid", {31'b0, m_vld}, 32'h0);
        fl = 1'b0; en = 1'b1; tick; tick;
        chk("flush stall after", {31'b0, m_vld}, 32'h0);

        // Asynchronous reset with a valid result on the output
        issue(32'd5, 32'd5, 2'b00); tick;
        ev = 1'b0; tick;
        chk("pre-reset valid", {31'b0, m_vld}, 32'h1);
        chk("pre-reset result", m_res, 32'h0000_0019);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", {31'b0, m_vld}, 32'h0);
        chk("async reset result", m_res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].op); tick;
            ev = 1'b0;
            chk($sformatf("vec%0d lat1 valid", i), {31'b0, m_vld}, 32'h0);
            tick;
            chk($sformatf("vec%0d valid", i), {31'b0, m_vld}, 32'h1);
            chk($sformatf("vec%0d result", i), m_res, vt[i].exp);
        end

        // Random regression across all widths and depths
        rst_n = 1'b0;
        sb_on = 1'b1;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            src1 = {$urandom, $urandom};
            src2 = {$urandom, $urandom};
            if ($urandom % 8 == 0) src1 = {4{16'h8000}};
            if ($urandom % 8 == 0) src2 = '1;
            op = 2'($urandom % 4);
            ev = ($urandom % 5 != 0);
            en = ($urandom % 4 != 0);
            fl = ($urandom % 25 == 0);
            tick;
        end
        ev = 1'b0; en = 1'b1; fl = 1'b0;
        repeat (4) tick;
        @(negedge clk);
        #1;
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_mult_cell_pipe.md
Name: nios_mult_cell_pipe

Overview:
- Parametrised pipelined integer multiplier cell for the CPU execute/memory stages. Next generation of the three-partial-product mult cell.
- Generates all four half-width partial products, including hi×hi, and assembles them internally.
- Returns a finished low or high product word, with full Nios II MUL/MULXUU/MULXSU/MULXSS semantics, a valid bit, stall and flush.
- Sits between the E-stage operand muxes and the M/A-stage result mux.

Parameters:
- DATA_W, 32, operand and result width; must be even, 16..64. HALF_W = DATA_W/2 is derived, not overridable.
- STAGES, 2, pipeline depth in enabled cycles, legal values 1..3.
  - 1: single output register.
  - 2: partial-product register, then output register.
  - 3: operand input register, then the STAGES=2 structure.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- E_src1  in  DATA_W  operand A
- E_src2  in  DATA_W  operand B
- E_op  in  2  operation: 00 MUL (low word), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS; 01/10/11 return the high word
- E_valid  in  1  operands/op valid this cycle
- M_en  in  1  pipeline advance enable; 0 = stall, all registers hold
- M_flush  in  1  kill all in-flight operations
- M_result  out  DATA_W  selected product word
- M_valid  out  1  M_result holds a completed operation
- M_busy  out  1  OR of the valid bits of every stage except the last

Behaviour:
- Reset (reset_n=0, asynchronous): every data, op and valid register clears to 0. M_result=0, M_valid=0, M_busy=0 from assertion until the first edge after deassertion. An operation in flight at reset is discarded with no output.
- Each stage holds data, op and valid. On a clk edge with M_en=1, every stage loads from its predecessor; stage 0 loads from E_src1/E_src2/E_op/E_valid. With M_en=0, nothing changes.
- Latency: an operation presented with E_valid=1 on an M_en=1 edge appears with M_valid=1 after exactly STAGES M_en=1 edges. Throughput is 1 per enabled cycle, with no bubbles.
- Partial products, all unsigned HALF_W×HALF_W → DATA_W:
  - pLL = aL·bL
  - pLH = aL·bH
  - pHL = aH·bL
  - pHH = aH·bH
- Assembly: unsigned 2·DATA_W product U = pLL + ((pLH+pHL) << HALF_W) + (pHH << DATA_W). The middle sum is carried at DATA_W+1 bits so no carry is lost.
- Sign correction on the high word, modulo 2^DATA_W:
  - MULXSU: Uhi − (A[msb] ? B : 0).
  - MULXSS: Uhi − (A[msb] ? B : 0) − (B[msb] ? A : 0).
  - MULXUU: Uhi unmodified.
  - MUL: Ulo; signedness is irrelevant.
- Op and signs travel with the data through every stage. Mixed ops back-to-back must each produce their own correct result.
- Flush (M_flush=1 at an edge): all valid bits clear at that edge regardless of M_en; data registers need not clear. If E_valid=1 at the same edge, the new operation is also killed. Flush has priority over stall.
- M_result with M_valid=0 is don't-care for consumers, but must be deterministic: it holds the last loaded value.
- Stall with M_valid=1: M_result and M_valid stay stable for the whole stall.
- STAGES=1: the full product is computed combinationally from the E inputs into the output register.
- Illegal parameters (odd DATA_W, STAGES outside 1..3): elaboration-time error.

Test Plan (DATA_W=32, STAGES=2 unless noted):
1. Product words:
   - MUL, A=0x0001_0003, B=0x0002_0005, E_valid=1, M_en=1 → after 2 edges M_valid=1, M_result=0x000B_000F.
   - Same operands, MULXUU → 0x0000_0002.
2. High-word sign handling, A=B=0xFFFF_FFFF:
   - MULXUU → 0xFFFF_FFFE.
   - MULXSS → 0x0000_0000.
   - MULXSU → 0xFFFF_FFFF.
   - Issued on consecutive cycles, the three results appear on consecutive cycles in that order.
3. Stall:
   - Issue MUL 7×6, drop M_en for 5 cycles after the first edge → M_valid stays 0 and nothing moves.
   - Raise M_en → M_result=0x0000_002A exactly one edge later; M_busy=1 during the stall.
4. Flush:
   - Two operations in flight, then M_flush=1 with E_valid=1 and MULXUU 3×4 → M_valid=0 for the next 2 edges, M_busy=0, no result emerges.
   - With M_en=0 the flush still clears the valid bits.
5. Reset mid-operation:
   - Assert reset_n=0 asynchronously between edges with M_valid=1 → M_result=0 and M_valid=0 immediately, without waiting for a clock edge.
   - After release, MUL 0x8000_0000×2 → 0x0000_0000; MULXSS on the same operands → 0xFFFF_FFFF.
6. Random regression, STAGES∈{1,2,3} × DATA_W∈{16,32,64}:
   - 10k random operands and ops, with random M_en/M_flush.
   - Each result is compared against a scoreboard computing a 2·DATA_W reference product; latency must equal STAGES enabled edges.
